// File: rtl/beta_cpu.sv
// Single-cycle Beta-ISA core: instruction ROM, 32x32 register file, ALU and data RAM.
// One instruction retires on each rising clk edge while runCPU is exactly 1.
module beta_cpu #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter string       IMEM_FILE  = "program.hex",
    parameter string       DMEM_FILE  = "",
    parameter logic [31:0] ILLOP_VEC  = 32'h0000_0004
) (
    input logic runCPU,
    input logic clk,
    input logic reset
);
    localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;
    localparam logic [4:0] R_XP   = 5'd30;
    localparam logic [4:0] R_ZERO = 5'd31;

    logic [31:0] imem    [IMEM_WORDS];
    logic [31:0] dmem    [DMEM_WORDS];
    logic [31:0] regfile [32];
    logic [31:0] pc;
    logic [31:0] pc_d;

    logic           run_en;
    logic [IAW-1:0] imem_idx;
    logic [DAW-1:0] dmem_idx;
    logic [31:0]    inst;
    logic [31:0]    pc4;
    logic [5:0]     op;
    logic [4:0]     rc;
    logic [4:0]     ra;
    logic [4:0]     rb;
    logic [4:0]     rb_sel;
    logic [31:0]    lit;
    logic [31:0]    ra_val;
    logic [31:0]    rb_val;
    logic [31:0]    ea;
    logic [31:0]    br_target;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_rdata;

    // X or Z on runCPU compares false, so only a clean 1 advances state.
    assign run_en    = (runCPU == 1'b1);
    assign imem_idx  = IAW'((pc >> 2) % IMEM_WORDS);
    assign inst      = imem[imem_idx];
    assign pc4       = pc + 32'd4;

    assign op        = inst[31:26];
    assign rc        = inst[25:21];
    assign ra        = inst[20:16];
    assign rb        = inst[15:11];
    assign lit       = {{16{inst[15]}}, inst[15:0]};

    // ST reads its data register (rc field) through the second read port.
    assign rb_sel    = (op == OP_ST) ? rc : rb;
    assign ra_val    = (ra == R_ZERO) ? 32'd0 : regfile[ra];
    assign rb_val    = (rb_sel == R_ZERO) ? 32'd0 : regfile[rb_sel];

    assign ea        = ra_val + lit;
    assign br_target = pc4 + {lit[29:0], 2'b00};
    assign mem_addr  = (op == OP_LDR) ? br_target : ea;
    assign dmem_idx  = DAW'((mem_addr >> 2) % DMEM_WORDS);
    assign mem_rdata = dmem[dmem_idx];

    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        alu_ok;

    // op[4] selects the literal forms (0x30..0x3E); op[3:0] names the function.
    always_comb begin
        alu_b  = op[4] ? lit : rb_val;
        alu_y  = 32'd0;
        alu_ok = 1'b1;
        case (op[3:0])
            4'h0:    alu_y = ra_val + alu_b;
            4'h1:    alu_y = ra_val - alu_b;
            4'h2:    alu_y = ra_val * alu_b;
            4'h4:    alu_y = {31'd0, ra_val == alu_b};
            4'h5:    alu_y = {31'd0, $signed(ra_val) <  $signed(alu_b)};
            4'h6:    alu_y = {31'd0, $signed(ra_val) <= $signed(alu_b)};
            4'h8:    alu_y = ra_val & alu_b;
            4'h9:    alu_y = ra_val | alu_b;
            4'hA:    alu_y = ra_val ^ alu_b;
            4'hC:    alu_y = ra_val << alu_b[4:0];
            4'hD:    alu_y = ra_val >> alu_b[4:0];
            4'hE:    alu_y = $signed(ra_val) >>> alu_b[4:0];
            default: alu_ok = 1'b0;
        endcase
    end

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        st_en;
    logic        illegal;

    always_comb begin
        pc_d    = pc4;
        wr_en   = 1'b0;
        wr_addr = rc;
        wr_data = alu_y;
        st_en   = 1'b0;
        illegal = 1'b0;
        if (op[5]) begin
            wr_en   = alu_ok;
            illegal = !alu_ok;
        end else begin
            case (op)
                OP_LD, OP_LDR: begin
                    wr_en   = 1'b1;
                    wr_data = mem_rdata;
                end
                OP_ST: st_en = 1'b1;
                OP_JMP: begin
                    wr_en   = 1'b1;
                    wr_data = pc4;
                    pc_d    = ra_val & ~32'd3;
                end
                OP_BEQ, OP_BNE: begin
                    wr_en   = 1'b1;
                    wr_data = pc4;
                    if ((ra_val == 32'd0) == (op == OP_BEQ)) pc_d = br_target;
                end
                default: illegal = 1'b1;
            endcase
        end
        // Trap: save the return address in XP and vector; nothing else is written.
        if (illegal) begin
            wr_en   = 1'b1;
            wr_addr = R_XP;
            wr_data = pc4;
            pc_d    = ILLOP_VEC;
        end
    end

    // dmem shares this block so reset also blocks stores, but it is never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= 32'd0;
            regfile <= '{default: 32'd0};
        end else if (run_en) begin
            pc <= pc_d;
            if (wr_en && wr_addr != R_ZERO) regfile[wr_addr] <= wr_data;
            if (st_en) dmem[dmem_idx] <= rb_val;
        end
    end

endmodule

// File: tb/tb_beta_cpu.sv
// Bench for beta_cpu: an instruction-level model of the Beta ISA is stepped alongside
// the core and compared every cycle; directed programs pin the model with literals.
module tb_beta_cpu;
    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic run_cpu = 1'b0;
    logic cmp_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    beta_cpu #(
        .IMEM_WORDS(256),
        .DMEM_WORDS(256),
        .IMEM_FILE (""),
        .DMEM_FILE (""),
        .ILLOP_VEC (32'h0000_0004)
    ) dut (
        .runCPU(run_cpu),
        .clk   (clk),
        .reset (reset)
    );

    logic [31:0] img     [256];
    logic [31:0] m_pc;
    logic [31:0] m_reg   [32];
    logic [31:0] m_mem   [256];
    bit          m_valid [256];

    logic [5:0] alu_ops [12] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26,
                                 6'h28, 6'h29, 6'h2A, 6'h2C, 6'h2D, 6'h2E};
    logic [5:0] bad_ops [8]  = '{6'h00, 6'h23, 6'h33, 6'h01, 6'h1A, 6'h1E, 6'h27, 6'h3F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
        return {op, rc, ra, lit};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rc,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {op, rc, ra, rb, 11'd0};
    endfunction

    // ---------------- behavioural model ----------------
    function automatic void model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[5'(i)] = 32'd0;
    endfunction

    function automatic logic [31:0] rget(input logic [4:0] r);
        return (r == 5'd31) ? 32'd0 : m_reg[r];
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        logic [7:0] w;
        w = 8'((addr >> 2) % 256);
        if (!m_valid[w]) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_mem_known: word %0d read before any store", w);
        end
        return m_mem[w];
    endfunction

    function automatic void mem_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] w;
        w = 8'((addr >> 2) % 256);
        m_mem[w]   = data;
        m_valid[w] = 1'b1;
    endfunction

    function automatic void model_step();
        logic [31:0] inst, a, b, c, lit, res, pc4, nxt;
        logic [5:0]  op, base;
        logic [4:0]  rc, ra, rb;
        bit          wr, bad;
        inst = img[8'((m_pc >> 2) % 256)];
        op   = inst[31:26];
        rc   = inst[25:21];
        ra   = inst[20:16];
        rb   = inst[15:11];
        lit  = {{16{inst[15]}}, inst[15:0]};
        a    = rget(ra);
        b    = rget(rb);
        c    = rget(rc);
        pc4  = m_pc + 32'd4;
        nxt  = pc4;
        res  = 32'd0;
        wr   = 1'b1;
        bad  = 1'b0;
        if (op >= 6'h20) begin
            base = op;
            if (op >= 6'h30) begin
                base = op - 6'h10;
                b    = lit;
            end
            case (base)
                6'h20:   res = a + b;
                6'h21:   res = a - b;
                6'h22:   res = a * b;
                6'h24:   res = (a == b) ? 32'd1 : 32'd0;
                6'h25:   res = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
                6'h26:   res = ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
                6'h28:   res = a & b;
                6'h29:   res = a | b;
                6'h2A:   res = a ^ b;
                6'h2C:   res = a << b[4:0];
                6'h2D:   res = a >> b[4:0];
                6'h2E:   res = $signed(a) >>> b[4:0];
                default: bad = 1'b1;
            endcase
        end else begin
            case (op)
                6'h18:   res = mem_rd(a + lit);
                6'h19:   begin mem_wr(a + lit, c); wr = 1'b0; end
                6'h1B:   begin res = pc4; nxt = {a[31:2], 2'b00}; end
                6'h1C:   begin res = pc4; if (a == 32'd0) nxt = pc4 + lit * 32'd4; end
                6'h1D:   begin res = pc4; if (a != 32'd0) nxt = pc4 + lit * 32'd4; end
                6'h1F:   res = mem_rd(pc4 + lit * 32'd4);
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            m_reg[30] = pc4;
            m_pc      = 32'h0000_0004;
        end else begin
            if (wr && rc != 5'd31) m_reg[rc] = res;
            m_pc = nxt;
        end
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1 && run_cpu === 1'b1) model_step();
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", dut.pc, m_pc);
            for (int i = 0; i < 32; i++)
                check($sformatf("r%0d", i), dut.regfile[5'(i)], m_reg[5'(i)]);
            for (int i = 0; i < 256; i++)
                if (m_valid[8'(i)]) check($sformatf("dmem%0d", i), dut.dmem[8'(i)], m_mem[8'(i)]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_rom();
        for (int p = 0; p < 256; p++) dut.imem[8'(p)] = img[8'(p)];
    endtask

    task automatic clear_img();
        for (int p = 0; p < 256; p++) img[8'(p)] = 32'd0;
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 32; i++) check($sformatf("%s_r%0d", tag, i), dut.regfile[5'(i)], 32'd0);
    endtask

    task automatic build_prog1();
        clear_img();
        img[0]  = enc(6'h30, 5'd1, 5'd31, 16'd5);
        img[1]  = enc(6'h30, 5'd2, 5'd31, 16'hFFFD);
        img[2]  = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
        img[3]  = enc_r(6'h25, 5'd4, 5'd2, 5'd1);
        img[4]  = enc(6'h3E, 5'd5, 5'd2, 16'd1);
        img[5]  = enc(6'h19, 5'd1, 5'd31, 16'd16);
        img[6]  = enc(6'h18, 5'd6, 5'd31, 16'd16);
        img[7]  = enc(6'h30, 5'd7, 5'd31, 16'h0043);
        img[8]  = enc(6'h1C, 5'd8, 5'd31, 16'd2);
        img[9]  = enc(6'h30, 5'd9, 5'd31, 16'd99);
        img[10] = enc(6'h30, 5'd9, 5'd31, 16'd99);
        img[11] = enc(6'h1D, 5'd10, 5'd31, 16'd5);
        img[12] = enc(6'h00, 5'd3, 5'd1, 16'h1234);
    endtask

    task automatic build_prog2();
        clear_img();
        img[0]  = enc(6'h30, 5'd7, 5'd31, 16'h0043);
        img[1]  = enc(6'h1B, 5'd8, 5'd7, 16'd0);
        img[2]  = enc(6'h30, 5'd9, 5'd31, 16'd1);
        img[16] = enc(6'h30, 5'd31, 5'd31, 16'd77);
        img[17] = enc(6'h30, 5'd1, 5'd31, 16'h1234);
        img[18] = enc(6'h19, 5'd1, 5'd31, 16'h0080);
        img[19] = enc(6'h1F, 5'd2, 5'd0, 16'd12);
        img[20] = enc(6'h18, 5'd3, 5'd31, 16'h0080);
        img[21] = enc(6'h19, 5'd1, 5'd31, 16'h0404);
        img[22] = enc(6'h18, 5'd4, 5'd31, 16'd4);
        img[23] = enc_r(6'h24, 5'd5, 5'd3, 5'd4);
        img[24] = enc(6'h1D, 5'd13, 5'd9, 16'd3);
        img[25] = enc(6'h30, 5'd9, 5'd31, 16'd1);
        img[26] = enc(6'h30, 5'd11, 5'd31, 16'h0444);
        img[27] = enc(6'h1B, 5'd12, 5'd11, 16'd0);
        img[28] = enc(6'h1C, 5'd31, 5'd31, 16'hFFFF);
    endtask

    // Random program: loads touch only words 0..15 (zeroed by the prologue) and all
    // control flow stays inside the ROM image so pc always equals 4*index.
    function automatic logic [31:0] rand_inst(input int p);
        int k;
        k = $urandom_range(0, 99);
        if (k < 35)
            return {alu_ops[$urandom_range(0, 11)], 5'($urandom), 5'($urandom), 5'($urandom), 11'($urandom)};
        else if (k < 60)
            return enc(alu_ops[$urandom_range(0, 11)] + 6'h10, 5'($urandom), 5'($urandom), 16'($urandom));
        else if (k < 68)
            return enc(6'h18, 5'($urandom), 5'd31, 16'($urandom_range(0, 63)));
        else if (k < 76)
            return enc(6'h19, 5'($urandom), 5'd31, 16'($urandom_range(0, 63)));
        else if (k < 80)
            return enc(6'h1F, 5'($urandom), 5'($urandom), 16'(int'($urandom_range(0, 15)) - (p + 1)));
        else if (k < 92)
            return enc(($urandom_range(0, 1) == 0) ? 6'h1C : 6'h1D, 5'($urandom), 5'($urandom),
                       16'(int'($urandom_range(0, 255)) - (p + 1)));
        else if (k < 94)
            return enc(6'h1B, 5'($urandom), 5'd31, 16'($urandom));
        else
            return enc(bad_ops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom), 16'($urandom));
    endfunction

    task automatic build_prog3();
        for (int p = 0; p < 16; p++) img[8'(p)] = enc(6'h19, 5'd31, 5'd31, 16'(4 * p));
        for (int p = 16; p < 255; p++) img[8'(p)] = rand_inst(p);
        img[255] = enc(6'h1B, 5'd31, 5'd31, 16'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) m_valid[8'(i)] = 1'b0;
        build_prog1();
        load_rom();
        #1;
        reset = 1'b0;
        model_reset();
        cmp_en = 1'b1;

        repeat (2) begin
            @(negedge clk);
            check("rst_pc", dut.pc, 32'd0);
        end
        check_regs_zero("rst");
        #1;
        reset   = 1'b1;
        run_cpu = 1'bx;
        repeat (2) begin
            @(negedge clk);
            check("gate_pc", dut.pc, 32'd0);
        end
        check_regs_zero("gate");
        #1;
        run_cpu = 1'b1;
        @(negedge clk); check("run_pc1", dut.pc, 32'd4);
        @(negedge clk); check("run_pc2", dut.pc, 32'd8);
        @(negedge clk); check("run_pc3", dut.pc, 32'd12);
        repeat (2) @(negedge clk);
        check("addc_r1", dut.regfile[1], 32'd5);
        check("addc_r2", dut.regfile[2], 32'hFFFF_FFFD);
        check("add_r3", dut.regfile[3], 32'd2);
        check("cmplt_r4", dut.regfile[4], 32'd1);
        check("srac_r5", dut.regfile[5], 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        check("st_dmem4", dut.dmem[4], 32'd5);
        check("ld_r6", dut.regfile[6], 32'd5);
        repeat (2) @(negedge clk);
        check("beq_pc", dut.pc, 32'h2C);
        check("beq_rc", dut.regfile[8], 32'h24);
        check("beq_skip_r9", dut.regfile[9], 32'd0);
        @(negedge clk);
        check("bne_pc", dut.pc, 32'h30);
        check("bne_rc", dut.regfile[10], 32'h30);
        @(negedge clk);
        check("ill_pc", dut.pc, 32'h4);
        check("ill_xp", dut.regfile[30], 32'h34);
        check("ill_r3", dut.regfile[3], 32'd2);
        check("ill_r10", dut.regfile[10], 32'h30);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_pc", dut.pc, 32'd0);
        check_regs_zero("midrst");
        check("midrst_dmem4", dut.dmem[4], 32'd5);

        @(negedge clk);
        build_prog2();
        load_rom();
        #1;
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("p2_pc", dut.pc, 32'h470);
        check("jmp_rc", dut.regfile[8], 32'd8);
        check("r31_zero", dut.regfile[31], 32'd0);
        check("ldr_r2", dut.regfile[2], 32'h1234);
        check("ld_r3", dut.regfile[3], 32'h1234);
        check("dwrap_r4", dut.regfile[4], 32'h1234);
        check("cmpeq_r5", dut.regfile[5], 32'd1);
        check("jmp2_rc", dut.regfile[12], 32'h70);
        check("iwrap_r13", dut.regfile[13], 32'h464);
        check("dwrap_dmem1", dut.dmem[1], 32'h1234);
        check("ldr_dmem32", dut.dmem[32], 32'h1234);

        #1;
        reset = 1'b0;
        model_reset();
        build_prog3();
        load_rom();
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (3000) begin
            int r;
            @(negedge clk);
            #1;
            r = $urandom_range(0, 19);
            run_cpu = (r == 0) ? 1'b0 : (r == 1) ? 1'bx : 1'b1;
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                reset = 1'b1;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
